// File: rtl/serial2tcp_tx_arbiter.sv
// Burst-granular round-robin arbiter that merges N_REQ byte streams onto the single
// serial2tcp sink. Each burst can optionally be preceded by an 8'hA0|id header byte.
module serial2tcp_tx_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 16,
    parameter int TAG_EN    = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic                 serial2tcp_sink_valid,
    input  logic                 serial2tcp_sink_ready,
    output logic [7:0]           serial2tcp_sink_data,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    next_ptr;
    logic               xfer;
    logic               burst_end;

    // Scan from the farthest position back to rr_ptr so the nearest requester wins last.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid[idx]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    assign next_ptr  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    assign xfer      = (state_q == ST_DATA) && req_valid[id_q] && serial2tcp_sink_ready;
    assign burst_end = xfer && (req_last[id_q] || (byte_cnt_q == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            byte_cnt_q <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            byte_cnt_q <= byte_cnt_d;
            grant_q    <= grant_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        rr_ptr_d              = rr_ptr_q;
        id_d                  = id_q;
        byte_cnt_d            = byte_cnt_q;
        grant_d               = grant_q;
        serial2tcp_sink_valid = 1'b0;
        serial2tcp_sink_data  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    id_d       = pick_id;
                    grant_d    = N_REQ'(1) << pick_id;
                    byte_cnt_d = '0;
                    state_d    = (TAG_EN != 0) ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                serial2tcp_sink_valid = 1'b1;
                serial2tcp_sink_data  = {4'hA, 4'(id_q)};
                if (serial2tcp_sink_ready) begin
                    state_d    = ST_DATA;
                    byte_cnt_d = '0;
                end
            end
            ST_DATA: begin
                serial2tcp_sink_valid = req_valid[id_q];
                serial2tcp_sink_data  = req_valid[id_q] ? req_data[8*int'(id_q) +: 8] : 8'h00;
                if (burst_end) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    byte_cnt_d = '0;
                    rr_ptr_d   = next_ptr;
                end else if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Only the owner sees the sink's ready, and only while its data is being passed through.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == ST_DATA) && grant_q[gi] && serial2tcp_sink_ready;
        end
    endgenerate

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial2tcp_tx_arbiter.sv
// Directed bench for serial2tcp_tx_arbiter: two requesters, one instance with
// MAX_BURST=16 and a second with MAX_BURST=4 for the round-robin burst-limit case.
module tb_serial2tcp_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic        sink_ready;

    logic [1:0]  req_ready, grant;
    logic        sink_valid, busy;
    logic [7:0]  sink_data;
    logic [1:0]  mb_req_ready, mb_grant;
    logic        mb_sink_valid, mb_busy;
    logic [7:0]  mb_sink_data;

    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [8:0]  src0[$];
    logic [8:0]  src1[$];
    logic [7:0]  sink_log[$];
    logic [7:0]  exp_log[$];
    logic [1:0]  stall;
    logic        use_mb;
    int          acc_cnt0, acc_cnt1;

    serial2tcp_tx_arbiter #(.N_REQ(2), .MAX_BURST(16), .TAG_EN(1)) u_dut (
        .sys_clk               (clk),
        .sys_rst               (srst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_data              (req_data),
        .req_last              (req_last),
        .serial2tcp_sink_valid (sink_valid),
        .serial2tcp_sink_ready (sink_ready),
        .serial2tcp_sink_data  (sink_data),
        .grant                 (grant),
        .busy                  (busy)
    );

    serial2tcp_tx_arbiter #(.N_REQ(2), .MAX_BURST(4), .TAG_EN(1)) u_dut_mb4 (
        .sys_clk               (clk),
        .sys_rst               (srst),
        .req_valid             (req_valid),
        .req_ready             (mb_req_ready),
        .req_data              (req_data),
        .req_last              (req_last),
        .serial2tcp_sink_valid (mb_sink_valid),
        .serial2tcp_sink_ready (sink_ready),
        .serial2tcp_sink_data  (mb_sink_data),
        .grant                 (mb_grant),
        .busy                  (mb_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        req_valid[0] = (src0.size() > 0) && !stall[0];
        req_valid[1] = (src1.size() > 0) && !stall[1];
        req_data[7:0]  = req_valid[0] ? src0[0][7:0] : 8'h00;
        req_data[15:8] = req_valid[1] ? src1[0][7:0] : 8'h00;
        req_last[0] = req_valid[0] && src0[0][8];
        req_last[1] = req_valid[1] && src1[0][8];
        #1;
    endtask

    // Records the transfers about to happen at the next edge, advances one clock,
    // then retires accepted requester bytes and re-drives the inputs.
    task automatic cycle();
        logic [1:0] acc;
        logic       sv;
        logic [7:0] sd;
        acc = req_valid & (use_mb ? mb_req_ready : req_ready);
        sv  = use_mb ? mb_sink_valid : sink_valid;
        sd  = use_mb ? mb_sink_data : sink_data;
        if (sv && sink_ready) begin
            sink_log.push_back(sd);
            $display("[TB] t=%0t sink byte %02h", $time, sd);
        end
        @(posedge clk);
        #1;
        if (acc[0] === 1'b1) begin
            void'(src0.pop_front());
            acc_cnt0++;
        end
        if (acc[1] === 1'b1) begin
            void'(src1.pop_front());
            acc_cnt1++;
        end
        drive_inputs();
    endtask

    task automatic check_log(input string tag);
        check_val({tag, "_len"}, sink_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            check_val($sformatf("%s_b%0d", tag, i),
                      (i < sink_log.size()) ? {24'h0, sink_log[i]} : 32'hFFFF, {24'h0, exp_log[i]});
        end
        sink_log.delete();
        exp_log.delete();
    endtask

    task automatic do_reset();
        src0.delete();
        src1.delete();
        stall = 2'b00;
        srst  = 1'b1;
        drive_inputs();
        cycle();
        cycle();
        srst = 1'b0;
        drive_inputs();
        sink_log.delete();
        acc_cnt0 = 0;
        acc_cnt1 = 0;
    endtask

    initial begin
        int n;
        logic [7:0] prev_data;
        logic       prev_stall;

        srst       = 1'b1;
        stall      = 2'b00;
        use_mb     = 1'b0;
        sink_ready = 1'b1;
        acc_cnt0   = 0;
        acc_cnt1   = 0;
        req_valid  = 2'b00;
        req_data   = 16'h0;
        req_last   = 2'b00;

        // Reset held with both requesters valid
        src0.push_back(9'h1EE);
        src1.push_back(9'h1EF);
        drive_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val($sformatf("rst%0d_sink_valid", i), sink_valid, 1'b0);
            check_val($sformatf("rst%0d_req_ready", i), req_ready, 2'b00);
            check_val($sformatf("rst%0d_grant", i), grant, 2'b00);
            check_val($sformatf("rst%0d_busy", i), busy, 1'b0);
        end
        do_reset();

        // Single tagged burst from req0
        src0.push_back(9'h011);
        src0.push_back(9'h022);
        src0.push_back(9'h133);
        drive_inputs();
        check_val("single_idle_grant", grant, 2'b00);
        cycle();
        check_val("single_hdr_grant", grant, 2'b01);
        check_val("single_hdr_valid", sink_valid, 1'b1);
        check_val("single_hdr_data", sink_data, 8'hA0);
        check_val("single_hdr_ready", req_ready, 2'b00);
        check_val("single_hdr_busy", busy, 1'b1);
        cycle();
        check_val("single_d0_data", sink_data, 8'h11);
        check_val("single_d0_ready", req_ready, 2'b01);
        cycle();
        cycle();
        check_val("single_d2_busy", busy, 1'b1);
        cycle();
        check_val("single_end_grant", grant, 2'b00);
        check_val("single_end_busy", busy, 1'b0);
        exp_log = '{8'hA0, 8'h11, 8'h22, 8'h33};
        check_log("single");

        // Round-robin with MAX_BURST=4, both requesters streaming without last
        do_reset();
        use_mb = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            src0.push_back({1'b0, 8'(i)});
            src1.push_back({1'b0, 8'(8'h80 + i)});
        end
        drive_inputs();
        repeat (18) cycle();
        exp_log.push_back(8'hA0);
        for (int i = 1; i <= 4; i++) exp_log.push_back(8'(i));
        exp_log.push_back(8'hA1);
        for (int i = 1; i <= 4; i++) exp_log.push_back(8'(8'h80 + i));
        exp_log.push_back(8'hA0);
        for (int i = 5; i <= 8; i++) exp_log.push_back(8'(i));
        check_log("rr");
        cycle();
        check_val("rr_req1_regrant", mb_grant, 2'b10);
        check_val("rr_req1_busy", mb_busy, 1'b1);
        use_mb = 1'b0;
        do_reset();

        // Alternating sink backpressure over a 5-byte burst
        for (int i = 1; i <= 5; i++) src0.push_back({(i == 5), 8'(8'h40 + i)});
        drive_inputs();
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        n = 0;
        while (sink_log.size() < 6 && n < 40) begin
            sink_ready = (n % 2 == 0);
            drive_inputs();
            if (prev_stall) begin
                check_val($sformatf("bp_hold_valid%0d", n), sink_valid, 1'b1);
                check_val($sformatf("bp_hold_data%0d", n), sink_data, prev_data);
            end
            prev_stall = sink_valid && !sink_ready;
            prev_data  = sink_data;
            cycle();
            n++;
        end
        sink_ready = 1'b1;
        drive_inputs();
        exp_log = '{8'hA0, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        check_log("bp");
        check_val("bp_accept_cnt", acc_cnt0, 5);
        check_val("bp_end_busy", busy, 1'b0);

        // Owner stalls mid-burst while req0 waits
        for (int i = 1; i <= 4; i++) src1.push_back({(i == 4), 8'(8'h60 + i)});
        src0.push_back(9'h051);
        src0.push_back(9'h152);
        drive_inputs();
        cycle();
        check_val("stall_grant_hdr", grant, 2'b10);
        cycle();
        cycle();
        cycle();
        stall[1] = 1'b1;
        drive_inputs();
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("stall%0d_grant", i), grant, 2'b10);
            check_val($sformatf("stall%0d_ready0", i), req_ready[0], 1'b0);
            check_val($sformatf("stall%0d_valid", i), sink_valid, 1'b0);
            cycle();
        end
        stall[1] = 1'b0;
        drive_inputs();
        n = 0;
        while ((src0.size() + src1.size() > 0 || busy) && n < 30) begin
            cycle();
            n++;
        end
        check_val("stall_drain_timeout", (n < 30), 1'b1);
        exp_log = '{8'hA1, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA0, 8'h51, 8'h52};
        check_log("stall");

        // Reset in the middle of a req1 burst
        for (int i = 1; i <= 6; i++) src1.push_back({(i == 6), 8'(8'h70 + i)});
        src0.push_back(9'h091);
        src0.push_back(9'h192);
        drive_inputs();
        repeat (4) cycle();
        check_val("mid_grant_pre", grant, 2'b10);
        check_val("mid_data_pre", sink_data, 8'h73);
        srst = 1'b1;
        drive_inputs();
        cycle();
        check_val("mid_rst_valid", sink_valid, 1'b0);
        check_val("mid_rst_data", sink_data, 8'h00);
        check_val("mid_rst_ready", req_ready, 2'b00);
        check_val("mid_rst_grant", grant, 2'b00);
        check_val("mid_rst_busy", busy, 1'b0);
        srst = 1'b0;
        drive_inputs();
        sink_log.delete();
        cycle();
        check_val("mid_rearb_grant", grant, 2'b01);
        check_val("mid_rearb_hdr", sink_data, 8'hA0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
